pp_accumulator: RTL and testbench



---
 rtl/mul16_pkg.sv | 29 ++
 rtl/partial_product.sv | 20 ++
 rtl/pp_accumulator.sv | 119 +++++++++++
 tb/tb_pp_accumulator.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul16_pkg.sv
// Shared types and widths for the 16x16 unsigned shift-add multiplier.
//   OP_W   : operand width (multiplicand / multiplier)
//   PROD_W : product width
//   CNT_W  : width of the step counter and the steps port (counts 0..16)
package mul16_pkg;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } acc_state_t;

  typedef bit [OP_W-1:0]   op_t;
  typedef bit [PROD_W-1:0] prod_t;

  // Zero-extend a partial product and move it to the weight of the
  // multiplier bit it was formed from.
  function automatic prod_t place_pp(input logic [OP_W-1:0] pp,
                                     input logic [CNT_W-1:0] sh);
    prod_t wide;
    wide = {{(PROD_W-OP_W){1'b0}}, pp};
    return wide << sh;
  endfunction

endpackage

// File: rtl/partial_product.sv
// Partial-product stage: gates every multiplicand bit with one multiplier bit.
//   a  : multiplicand
//   b  : single multiplier bit
//   pp : a when b is 1, zero otherwise
module partial_product
  import mul16_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic            b,
  output logic [OP_W-1:0] pp
);

  genvar gi;
  generate
    for (gi = 0; gi < OP_W; gi++) begin : g_and
      assign pp[gi] = a[gi] & b;
    end
  endgenerate

endmodule

// File: rtl/pp_accumulator.sv
// Sequential shift-add multiplier core: one partial product per RUN cycle is
// shifted to its bit weight and added into a 32-bit accumulator.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (ready only in IDLE)
//   a, b                : multiplicand, multiplier (unsigned)
//   out_valid/out_ready : product handshake (valid only in DONE)
//   product             : a*b, held until the output handshake completes
//   steps               : RUN cycles used for the current/last product
// EARLY_EXIT=1 stops as soon as no set multiplier bits remain.
module pp_accumulator
  import mul16_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic [CNT_W-1:0]  steps
);

  acc_state_t       state_reg, state_next;
  op_t              mcand_reg, mcand_next;
  op_t              mplier_reg, mplier_next;
  prod_t            acc_reg, acc_next;
  prod_t            product_reg, product_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] steps_reg, steps_next;

  logic [OP_W-1:0]  pp;
  prod_t            acc_sum;
  logic             last_step;

  partial_product u_pp (
    .a  (mcand_reg),
    .b  (mplier_reg[0]),
    .pp (pp)
  );

  assign acc_sum = acc_reg + place_pp(pp, cnt_reg);

  // Stop after the 16th bit, or early once the bits still to be consumed
  // (everything above the one used this cycle) are all zero.
  assign last_step = (cnt_reg == CNT_W'(OP_W - 1)) ||
                     (EARLY_EXIT && ((mplier_reg >> 1) == '0));

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign product   = product_reg;
  assign steps     = steps_reg;

  always_comb begin
    state_next   = state_reg;
    mcand_next   = mcand_reg;
    mplier_next  = mplier_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    steps_next   = steps_reg;
    product_next = product_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          mcand_next  = a;
          mplier_next = b;
          acc_next    = '0;
          cnt_next    = '0;
          steps_next  = '0;
          state_next  = RUN;
        end
      end
      RUN: begin
        acc_next    = acc_sum;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + 1'b1;
        steps_next  = cnt_reg + 1'b1;
        if (last_step) begin
          // Capture the finished sum directly so product is valid in DONE.
          product_next = acc_sum;
          state_next   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      steps_reg   <= '0;
      product_reg <= '0;
    end else begin
      state_reg   <= state_next;
      mcand_reg   <= mcand_next;
      mplier_reg  <= mplier_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      steps_reg   <= steps_next;
      product_reg <= product_next;
    end
  end

endmodule

// File: tb/tb_pp_accumulator.sv
// Bench for pp_accumulator: one instance with early exit (index 0) and one
// running full 16 steps (index 1). Issued operations push their expected
// product/steps into a per-instance queue; a monitor checks the outputs.
module tb_pp_accumulator;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] product;
    logic [4:0]  steps;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid_r [2];
  logic        in_ready_w [2];
  logic [15:0] a_r [2];
  logic [15:0] b_r [2];
  logic        out_valid_w [2];
  logic        out_ready_r [2];
  logic [31:0] product_w [2];
  logic [4:0]  steps_w [2];

  exp_t q [2][$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   accept_cyc [2];
  bit   busy [2];
  bit   was_valid [2];
  bit   lat_done [2];

  always #5 clk = ~clk;

  pp_accumulator #(.EARLY_EXIT(1'b1)) dut_e (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_r[0]), .in_ready(in_ready_w[0]),
    .a(a_r[0]), .b(b_r[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready_r[0]),
    .product(product_w[0]), .steps(steps_w[0])
  );

  pp_accumulator #(.EARLY_EXIT(1'b0)) dut_f (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_r[1]), .in_ready(in_ready_w[1]),
    .a(a_r[1]), .b(b_r[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready_r[1]),
    .product(product_w[1]), .steps(steps_w[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // Reference step count: highest set bit index + 1 (b==0 -> 1), or 16.
  function automatic logic [4:0] ref_steps(input bit early, input logic [15:0] bv);
    logic [4:0] s;
    if (!early) return 5'd16;
    s = 5'd1;
    for (int k = 0; k < 16; k++) if (bv[k]) s = 5'(k + 1);
    return s;
  endfunction

  // Posedge tracker: acceptance time and busy (between accept and drain).
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          busy[i] = 1'b0;
        end else if (in_valid_r[i] && in_ready_w[i]) begin
          busy[i] = 1'b1;
          accept_cyc[i] = cyc;
        end else if (out_valid_w[i] && out_ready_r[i]) begin
          busy[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: compares every cycle that out_valid is up, pops when it drops.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          was_valid[i] = 1'b0;
          lat_done[i]  = 1'b0;
        end else begin
          chk($sformatf("in_ready%0d", i), 32'(in_ready_w[i]), 32'(!busy[i]));
          if (out_valid_w[i]) begin
            if (q[i].size() == 0) begin
              if (!was_valid[i]) begin
                n_cmp++;
                n_fail++;
                $display("FAIL spurious_out%0d: product 0x%0h with no pending operation", i, product_w[i]);
              end
            end else begin
              e = q[i][0];
              if (!lat_done[i]) begin
                chk($sformatf("latency%0d", i), 32'(cyc - accept_cyc[i]), 32'(e.steps));
                lat_done[i] = 1'b1;
              end
              chk($sformatf("product%0d", i), product_w[i], e.product);
              chk($sformatf("steps%0d", i), 32'(steps_w[i]), 32'(e.steps));
            end
            was_valid[i] = 1'b1;
          end else if (was_valid[i]) begin
            if (q[i].size() != 0) begin
              e = q[i].pop_front();
              $display("dut%0d: 0x%04h * 0x%04h -> 0x%08h steps %0d", i, e.a, e.b, e.product, e.steps);
            end
            was_valid[i] = 1'b0;
            lat_done[i]  = 1'b0;
          end
        end
      end
    end
  end

  task automatic issue(input int i, input logic [15:0] av, input logic [15:0] bv,
                       input logic [31:0] ep, input logic [4:0] es,
                       input bit push, input bit hold);
    int   n;
    bit   ok;
    exp_t e;
    @(negedge clk);
    a_r[i] = av;
    b_r[i] = bv;
    in_valid_r[i] = 1'b1;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(posedge clk);
      n++;
      if (in_ready_w[i]) ok = 1'b1;
    end
    if (!ok) begin
      fail_timeout($sformatf("accept%0d", i));
    end else if (push) begin
      e.a = av; e.b = bv; e.product = ep; e.steps = es;
      q[i].push_back(e);
    end
    if (!hold) begin
      @(negedge clk);
      in_valid_r[i] = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0 || busy[0] || busy[1]) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) fail_timeout("drain");
  endtask

  task automatic run_b2b(input int i);
    logic [15:0] av [10];
    logic [15:0] bv [10];
    av = '{16'h0000, 16'hFFFF, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h8001,
           16'(($urandom)), 16'(($urandom)), 16'(($urandom)), 16'h0001};
    bv = '{16'h1234, 16'h0000, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h4000,
           16'(($urandom)), 16'(($urandom)), 16'(($urandom)), 16'h0001};
    for (int k = 0; k < 10; k++) begin
      issue(i, av[k], bv[k], {16'h0, av[k]} * {16'h0, bv[k]},
            ref_steps(i == 0, bv[k]), 1'b1, k != 9);
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      in_valid_r[i]  = 1'b0;
      out_ready_r[i] = 1'b1;
      a_r[i] = '0;
      b_r[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_out_valid%0d", i), 32'(out_valid_w[i]), 32'd0);
      chk($sformatf("rst_product%0d", i), product_w[i], 32'd0);
      chk($sformatf("rst_steps%0d", i), 32'(steps_w[i]), 32'd0);
      chk($sformatf("rst_in_ready%0d", i), 32'(in_ready_w[i]), 32'd1);
    end

    // Full width, 16 steps, no early exit.
    issue(1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 5'd16, 1'b1, 1'b0);
    wait_drain();
    // Early exit on small / zero multipliers.
    issue(0, 16'h1234, 16'h0001, 32'h00001234, 5'd1, 1'b1, 1'b0);
    issue(0, 16'hABCD, 16'h0000, 32'h00000000, 5'd1, 1'b1, 1'b0);
    // Same operands on both flavours.
    issue(0, 16'h00FF, 16'h0100, 32'h0000FF00, 5'd9, 1'b1, 1'b0);
    issue(1, 16'h00FF, 16'h0100, 32'h0000FF00, 5'd16, 1'b1, 1'b0);
    wait_drain();

    // Backpressure: hold out_ready low for 10 cycles of out_valid.
    out_ready_r[0] = 1'b0;
    issue(0, 16'd3, 16'd5, 32'd15, 5'd3, 1'b1, 1'b0);
    n = 0;
    while (!out_valid_w[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_timeout("bp_out_valid");
    for (int k = 0; k < 10; k++) begin
      chk("bp_product", product_w[0], 32'd15);
      chk("bp_in_ready", 32'(in_ready_w[0]), 32'd0);
      @(negedge clk);
    end
    out_ready_r[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 32'(in_ready_w[0]), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid_w[0]), 32'd0);
    wait_drain();

    // Reset in the middle of a run discards it.
    issue(0, 16'h8000, 16'h8000, 32'h0, 5'd0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid_w[0]), 32'd0);
    chk("midrst_product", product_w[0], 32'd0);
    chk("midrst_in_ready", 32'(in_ready_w[0]), 32'd1);
    issue(0, 16'd2, 16'd3, 32'd6, 5'd2, 1'b1, 1'b0);
    issue(1, 16'd2, 16'd3, 32'd6, 5'd16, 1'b1, 1'b0);
    wait_drain();

    // Back-to-back with in_valid held high on both instances.
    fork
      run_b2b(0);
      run_b2b(1);
    join
    @(negedge clk);
    in_valid_r[0] = 1'b0;
    in_valid_r[1] = 1'b0;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
